// File: rtl/load_store_unit.sv
// Load/store unit: size/alignment checks, byte/half extraction on loads and
// read-modify-write merging for sub-word stores against a single-port word memory.
module load_store_unit #(
    parameter int unsigned MEM_DEPTH = 4097
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned IDX_W = 30;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE, LOAD, WR, RMW_RD, RMW_WR, RESP
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;

    logic        accept_c, err_c, err_d;
    logic [31:0] addr_d, wdata_d;
    logic        req_ready_d, rsp_valid_d, rsp_err_d, mem_we_d;
    logic [31:0] rsp_rdata_d, mem_addr_d, mem_wdata_d;

    // Pull the addressed byte/half down to bit 0 and extend; words pass through.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (size)
            2'b00:   extract = uns ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            2'b01:   extract = uns ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default: extract = w;
        endcase
    endfunction

    // Overlay the store data onto its lane of the old word.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] off);
        logic [31:0] mask, data;
        if (size == 2'b00) begin
            mask = 32'h0000_00FF << {off, 3'b000};
            data = {24'h0, wd[7:0]} << {off, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {off[1], 4'b0000};
            data = {16'h0, wd[15:0]} << {off[1], 4'b0000};
        end
        merge = (w & ~mask) | (data & mask);
    endfunction

    always_comb begin
        accept_c = req_valid && req_ready;
        case (req_size)
            2'b00:   err_c = 1'b0;
            2'b01:   err_c = req_addr[0];
            2'b10:   err_c = |req_addr[1:0];
            default: err_c = 1'b1;
        endcase
        if (req_addr[31:2] >= DEPTH_IDX) begin
            err_c = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (err_c)                  state_d = RESP;
                    else if (!req_we)           state_d = LOAD;
                    else if (req_size == 2'b10) state_d = WR;
                    else                        state_d = RMW_RD;
                end
            end
            LOAD:    state_d = RESP;
            WR:      state_d = RESP;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values, computed from the upcoming state so every output is a flop.
    always_comb begin
        addr_d      = accept_c ? req_addr  : addr_q;
        wdata_d     = accept_c ? req_wdata : wdata_q;
        err_d       = accept_c ? err_c     : err_q;
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        rsp_err_d   = (state_d == RESP) && err_d;
        rsp_rdata_d = '0;
        mem_we_d    = (state_d == WR) || (state_d == RMW_WR);
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (state_d != IDLE) begin
            mem_addr_d = {2'b00, addr_d[31:2]};
        end
        if (state_q == LOAD && !we_q) begin
            rsp_rdata_d = extract(mem_rdata, size_q, addr_q[1:0], uns_q);
        end
        // The mem_wdata register doubles as the read-modify-write merge register.
        if (state_d == WR) begin
            mem_wdata_d = wdata_d;
        end else if (state_d == RMW_WR) begin
            mem_wdata_d = merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            if (accept_c) begin
                we_q   <= req_we;
                size_q <= req_size;
                uns_q  <= req_unsigned;
            end
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 4097: number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port srst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  memory-stage request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  misaligned, illegal-size or out-of-range access.
REQ-014 SHALL have port mem_we  output  1  data memory write enable.
REQ-015 SHALL have port mem_addr  output  32  word index to data memory ({2'b0, addr[31:2]}).
REQ-016 SHALL have port mem_wdata  output  32  data memory write data.
REQ-017 SHALL have port mem_rdata  input  32  data memory combinational read data for mem_addr.

Function
REQ-018 SHALL implement states IDLE, LOAD, WR, RMW_RD, RMW_WR, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL register req_we, req_size, req_unsigned, req_addr, req_wdata and an error flag on acceptance; inputs are ignored in all other states.
REQ-020 SHALL flag an error when req_size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= MEM_DEPTH.
REQ-021 SHALL transition IDLE on accept: error -> RESP; load -> LOAD; word store -> WR; byte/half store -> RMW_RD.
REQ-022 SHALL transition LOAD -> RESP and capture the extracted load value from mem_rdata.
REQ-023 SHALL transition WR -> RESP with mem_we=1 and mem_wdata=captured wdata for exactly that cycle.
REQ-024 SHALL capture mem_rdata in RMW_RD into a merge register, then in RMW_WR drive mem_we=1 with the merged word, then go to RESP.
REQ-025 SHALL merge a byte store into lane addr[1:0] (bits 8k+7:8k := wdata[7:0]) and a half store into lane addr[1] (bits 16h+15:16h := wdata[15:0]), leaving the other bits unchanged.
REQ-026 SHALL extract a byte load from lane addr[1:0] and a half load from lane addr[1], extended per req_unsigned; word loads are passed through unchanged.
REQ-027 SHALL, in RESP, assert rsp_valid for one cycle with rsp_rdata/rsp_err valid, then return to IDLE; a new request is accepted the cycle after RESP.
REQ-028 SHALL drive mem_addr from the captured address in all non-IDLE states and 0 in IDLE.
REQ-029 SHALL assert mem_we only in WR and RMW_RD-followed RMW_RD->RMW_WR (i.e. RMW_WR) and never for error accesses.
REQ-030 SHALL meet latencies from accept cycle T: error rsp at T+1; load and word store rsp at T+2; byte/half store rsp at T+3.

Reset
REQ-031 SHALL, while srst_n=0, force state IDLE, clear all registers, and drive rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata and req_ready to 0.
REQ-032 SHALL abort any in-flight access when reset asserts: no subsequent mem_we and no response; req_ready=1 on the first clock edge after release.

Verification
REQ-033 SHALL pass: word 2 = 0x00000004, lw 0x8 -> rsp_valid at T+2, rsp_rdata=0x00000004, rsp_err=0.
REQ-034 SHALL pass: sw 0x8000FF80 to 0x4, then lb 0x4 -> 0xFFFFFF80; lbu 0x5 -> 0x000000FF; lh 0x6 -> 0xFFFF8000; lhu 0x6 -> 0x00008000.
REQ-035 SHALL pass: word 2 = 0x00000004, sb 0xAB to 0x9 -> mem_we at T+2 with mem_addr=2 and mem_wdata=0x0000AB04; rsp at T+3; lw 0x8 -> 0x0000AB04.
REQ-036 SHALL pass: lw 0x6, sh 0x3, req_size=11 and lw 0x4004 -> each gives rsp_valid at T+1 with rsp_err=1, rsp_rdata=0, and no mem_we.
REQ-037 SHALL pass: srst_n pulsed low during RMW_RD of sb 0x1 -> mem_we stays 0, no rsp_valid, and word 0 is unchanged.
REQ-038 SHALL pass: req_valid held high over three back-to-back loads -> each accepted only in IDLE, with responses at T+2, T+5, T+8.
